// File: rtl/i2s_transmitter.sv
// Philips-format I2S transmitter: divides clk down to sck, serializes one stereo
// frame per 2*SLOT_BITS sck cycles, and buffers one pending sample pair.
module i2s_transmitter #(
  parameter int DATA_SIZE    = 24,
  parameter int SLOT_BITS    = 32,
  parameter int CLK_FREQ     = 100_000_000,
  parameter int I2S_CLK_FREQ = 1_500_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  input  logic [DATA_SIZE-1:0] sample_left,
  input  logic [DATA_SIZE-1:0] sample_right,
  output logic                 i2s_sck,
  output logic                 i2s_ws,
  output logic                 i2s_sd,
  output logic                 frame_start,
  output logic                 underrun,
  output logic [15:0]          underrun_count
);

  localparam int CLK_DIV    = CLK_FREQ / (2 * I2S_CLK_FREQ);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit;
  logic                  r_sck;
  logic                  r_ws;
  logic                  r_sd;
  logic [FRAME_BITS-1:0] r_shift;
  logic [DATA_SIZE-1:0]  r_hold_left;
  logic [DATA_SIZE-1:0]  r_hold_right;
  logic                  r_full;
  logic                  r_frame_start;
  logic                  r_underrun;
  logic [15:0]           r_underrun_count;

  logic                  w_div_wrap;
  logic                  w_fall;
  logic                  w_accept;
  logic                  w_frame_load;
  logic [SLOT_BITS-1:0]  w_left_slot;
  logic [SLOT_BITS-1:0]  w_right_slot;

  assign w_div_wrap   = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_fall       = enable && w_div_wrap && r_sck;
  assign w_accept     = sample_valid && !r_full;
  assign w_frame_load = w_fall && (r_bit == '0);

  // Samples sit left-justified in their slots with zero padding below the LSB.
  assign w_left_slot  = SLOT_BITS'(r_hold_left)  << (SLOT_BITS - DATA_SIZE);
  assign w_right_slot = SLOT_BITS'(r_hold_right) << (SLOT_BITS - DATA_SIZE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_full       <= 1'b0;
      r_hold_left  <= '0;
      r_hold_right <= '0;
    end else if (w_accept) begin
      r_full       <= 1'b1;
      r_hold_left  <= sample_left;
      r_hold_right <= sample_right;
    end else if (w_frame_load) begin
      r_full <= 1'b0;
    end
  end

  // sd lags the shift register by one fall event, which produces the Philips
  // one-bit delay: the last right-slot bit leaves on the next frame's b=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div            <= '0;
      r_bit            <= '0;
      r_sck            <= 1'b0;
      r_ws             <= 1'b0;
      r_sd             <= 1'b0;
      r_shift          <= '0;
      r_frame_start    <= 1'b0;
      r_underrun       <= 1'b0;
      r_underrun_count <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (!enable) begin
        r_div   <= '0;
        r_bit   <= '0;
        r_sck   <= 1'b0;
        r_ws    <= 1'b0;
        r_sd    <= 1'b0;
        r_shift <= '0;
      end else begin
        if (w_div_wrap) begin
          r_div <= '0;
          r_sck <= ~r_sck;
        end else begin
          r_div <= r_div + 1'b1;
        end
        if (w_fall) begin
          r_ws  <= (r_bit >= BIT_W'(SLOT_BITS));
          r_sd  <= r_shift[FRAME_BITS-1];
          r_bit <= (r_bit == BIT_W'(FRAME_BITS - 1)) ? '0 : r_bit + 1'b1;
          if (r_bit == '0) begin
            if (r_full) begin
              r_shift       <= {w_left_slot, w_right_slot};
              r_frame_start <= 1'b1;
            end else begin
              r_shift    <= '0;
              r_underrun <= 1'b1;
              if (r_underrun_count != 16'hFFFF) begin
                r_underrun_count <= r_underrun_count + 16'd1;
              end
            end
          end else begin
            r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign sample_ready   = !r_full;
  assign i2s_sck        = r_sck;
  assign i2s_ws         = r_ws;
  assign i2s_sd         = r_sd;
  assign frame_start    = r_frame_start;
  assign underrun       = r_underrun;
  assign underrun_count = r_underrun_count;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter with CLK_DIV=4, 24-bit samples in 32-bit slots;
// outputs are sampled 1 ns after each rising clk edge.
module tb_i2s_transmitter;

  localparam int DATA_SIZE    = 24;
  localparam int SLOT_BITS    = 32;
  localparam int CLK_FREQ     = 8;
  localparam int I2S_CLK_FREQ = 1;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        sample_valid;
  logic        sample_ready;
  logic [23:0] sample_left;
  logic [23:0] sample_right;
  logic        i2s_sck;
  logic        i2s_ws;
  logic        i2s_sd;
  logic        frame_start;
  logic        underrun;
  logic [15:0] underrun_count;

  int          checks;
  int          failures;
  int          nUnderrun;
  int          nStart;
  int          nAccept;
  int          streamIdx;
  bit          streaming;
  logic [63:0] sdBits;
  logic [63:0] wsBits;
  logic [63:0] expFrame;
  int          badPeriods;

  i2s_transmitter #(
    .DATA_SIZE   (DATA_SIZE),
    .SLOT_BITS   (SLOT_BITS),
    .CLK_FREQ    (CLK_FREQ),
    .I2S_CLK_FREQ(I2S_CLK_FREQ)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .sample_left   (sample_left),
    .sample_right  (sample_right),
    .i2s_sck       (i2s_sck),
    .i2s_ws        (i2s_ws),
    .i2s_sd        (i2s_sd),
    .frame_start   (frame_start),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] frameOf(input logic [23:0] l, input logic [23:0] r);
    return {l, 8'h00, r, 8'h00};
  endfunction

  function automatic logic [23:0] streamL(input int i);
    return 24'h800001 + 24'(i) * 24'h010203;
  endfunction

  function automatic logic [23:0] streamR(input int i);
    return 24'h400000 + 24'(i) * 24'h000111;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clk: note a pending handshake at negedge, then sample outputs just past posedge.
  task automatic tick();
    logic acc;
    @(negedge clk);
    acc = sample_valid && sample_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      nAccept++;
      if (streaming) begin
        streamIdx++;
        sample_left  = streamL(streamIdx);
        sample_right = streamR(streamIdx);
      end
    end
    if (underrun)    nUnderrun++;
    if (frame_start) nStart++;
  endtask

  task automatic applyStimulus(input logic [23:0] l, input logic [23:0] r);
    sample_left  = l;
    sample_right = r;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic waitFall(output int cycles);
    logic prev;
    bit   done;
    cycles = 0;
    done   = 0;
    while (!done && cycles < 64) begin
      prev = i2s_sck;
      tick();
      cycles++;
      if (prev && !i2s_sck) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $error("[TB] FAIL fall_timeout: observed=no sck fall in %0d clk expected=fall within 64 clk", cycles);
    end
  endtask

  task automatic runFrame(input int n, output logic [63:0] sdv, output logic [63:0] wsv, output int bad);
    int c;
    sdv = '0;
    wsv = '0;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      waitFall(c);
      if (c != 8) bad++;
      sdv = {sdv[62:0], i2s_sd};
      wsv = {wsv[62:0], i2s_ws};
    end
  endtask

  task automatic checkStartup(input string tag);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 3) checkOutput({tag, "_sck_e3"}, i2s_sck, 1'b0);
      if (e == 4) checkOutput({tag, "_sck_e4"}, i2s_sck, 1'b1);
      if (e == 7) checkOutput({tag, "_sck_e7"}, i2s_sck, 1'b1);
      if (e == 8) begin
        checkOutput({tag, "_sck_e8"}, i2s_sck, 1'b0);
        checkOutput({tag, "_fs_e8"}, frame_start, 1'b1);
        checkOutput({tag, "_ws_e8"}, i2s_ws, 1'b0);
        checkOutput({tag, "_sd_e8"}, i2s_sd, 1'b0);
      end
    end
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    nUnderrun    = 0;
    nStart       = 0;
    nAccept      = 0;
    streamIdx    = 0;
    streaming    = 0;
    rst_n        = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_left  = '0;
    sample_right = '0;

    repeat (3) tick();
    checkOutput("rst_sck", i2s_sck, 1'b0);
    checkOutput("rst_ws", i2s_ws, 1'b0);
    checkOutput("rst_sd", i2s_sd, 1'b0);
    checkOutput("rst_frame_start", frame_start, 1'b0);
    checkOutput("rst_underrun", underrun, 1'b0);
    checkOutput("rst_count", underrun_count, 16'h0000);
    rst_n = 1'b1;
    tick();
    checkOutput("ready_after_rst", sample_ready, 1'b1);

    // First frame carries A5A5A5 / 00000F.
    applyStimulus(24'hA5A5A5, 24'h00000F);
    checkOutput("ready_after_load", sample_ready, 1'b0);
    checkOutput("sck_idle_disabled", i2s_sck, 1'b0);
    enable = 1'b1;
    checkStartup("start");
    nUnderrun = 0;
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("frame1_sd", sdBits, frameOf(24'hA5A5A5, 24'h00000F));
    checkOutput("frame1_ws", wsBits, 64'h0000_0001_FFFF_FFFE);
    checkOutput("frame1_period", 64'(badPeriods), 64'd0);
    checkOutput("frame1_end_underrun", underrun, 1'b1);
    checkOutput("count_1", underrun_count, 16'd1);

    // Starved frames transmit silence and count underruns.
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("starve2_sd", sdBits, 64'h0);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("starve3_sd", sdBits, 64'h0);
    checkOutput("count_3", underrun_count, 16'd3);
    checkOutput("underrun_pulses_3", 64'(nUnderrun), 64'd3);

    force dut.r_underrun_count = 16'hFFFE;
    tick();
    release dut.r_underrun_count;
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("count_ffff", underrun_count, 16'hFFFF);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("count_saturated", underrun_count, 16'hFFFF);
    checkOutput("underrun_at_sat", underrun, 1'b1);

    // Continuous valid: one sample per frame, none lost.
    streaming    = 1;
    streamIdx    = 0;
    nAccept      = 0;
    nUnderrun    = 0;
    nStart       = 0;
    sample_left  = streamL(0);
    sample_right = streamR(0);
    sample_valid = 1'b1;
    tick();
    checkOutput("stream_ready_drop", sample_ready, 1'b0);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("stream_fs0", frame_start, 1'b1);
    checkOutput("stream_ready_at_fs0", sample_ready, 1'b1);
    tick();
    checkOutput("stream_ready_after_fs0", sample_ready, 1'b0);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("stream_sd0", sdBits, frameOf(streamL(0), streamR(0)));
    checkOutput("stream_ready_at_fs1", sample_ready, 1'b1);
    tick();
    checkOutput("stream_ready_after_fs1", sample_ready, 1'b0);
    sample_valid = 1'b0;
    streaming    = 0;
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("stream_sd1", sdBits, frameOf(streamL(1), streamR(1)));
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("stream_sd2", sdBits, frameOf(streamL(2), streamR(2)));
    checkOutput("stream_accepts", 64'(nAccept), 64'd3);
    checkOutput("stream_starts", 64'(nStart), 64'd3);
    checkOutput("stream_underruns", 64'(nUnderrun), 64'd1);

    // Sample offered in the same clk as an empty b=0 fall event.
    runFrame(63, sdBits, wsBits, badPeriods);
    repeat (7) tick();
    sample_left  = 24'h123456;
    sample_right = 24'h654321;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    checkOutput("late_fall_seen", i2s_sck, 1'b0);
    checkOutput("late_underrun", underrun, 1'b1);
    checkOutput("late_no_fs", frame_start, 1'b0);
    checkOutput("late_ready", sample_ready, 1'b0);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("late_frame_silent", sdBits, 64'h0);
    checkOutput("late_fs_next", frame_start, 1'b1);
    applyStimulus(24'hABCDEF, 24'h0F0F0F);
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("late_frame_sent", sdBits, frameOf(24'h123456, 24'h654321));

    // Abort at b=40, then resume with the held sample.
    applyStimulus(24'h7FFFFF, 24'h800000);
    runFrame(40, sdBits, wsBits, badPeriods);
    expFrame = frameOf(24'hABCDEF, 24'h0F0F0F);
    checkOutput("abort_partial_sd", sdBits[39:0], expFrame[63:24]);
    repeat (5) tick();
    checkOutput("abort_pre_sck", i2s_sck, 1'b1);
    checkOutput("abort_pre_ws", i2s_ws, 1'b1);
    checkOutput("abort_pre_sd", i2s_sd, 1'b1);
    enable = 1'b0;
    tick();
    checkOutput("abort_sck", i2s_sck, 1'b0);
    checkOutput("abort_ws", i2s_ws, 1'b0);
    checkOutput("abort_sd", i2s_sd, 1'b0);
    repeat (10) tick();
    checkOutput("disabled_sck", i2s_sck, 1'b0);
    checkOutput("disabled_held", sample_ready, 1'b0);
    enable = 1'b1;
    checkStartup("restart");
    runFrame(64, sdBits, wsBits, badPeriods);
    checkOutput("restart_frame", sdBits, frameOf(24'h7FFFFF, 24'h800000));

    // Reset mid-frame drops the pending sample and clears the counter.
    applyStimulus(24'h111111, 24'h222222);
    checkOutput("pre_reset_ready", sample_ready, 1'b0);
    runFrame(10, sdBits, wsBits, badPeriods);
    rst_n = 1'b0;
    tick();
    checkOutput("midrst_sck", i2s_sck, 1'b0);
    checkOutput("midrst_sd", i2s_sd, 1'b0);
    checkOutput("midrst_count", underrun_count, 16'h0000);
    checkOutput("midrst_ready", sample_ready, 1'b1);
    rst_n  = 1'b1;
    enable = 1'b0;
    tick();
    checkOutput("post_rst_count", underrun_count, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
